ahb_master_arbiter: RTL
=======================

Name: ahb_master_arbiter

Overview:
- Shares the single AHB-Lite master port between the instruction fetch unit (IFU) and the memory access unit (MAU) load/store path.
- Arbitrates requests and sequences one AHB transfer at a time through its address and data phases.
- Returns read data and completion/error status to the winning requester.
- Sits between the core's fetch/MAU request logic and the system AHB interconnect.

Parameters:
STARVE_MAX, 4, max consecutive MAU grants while IFU is requesting before IFU is forced to win (1..15)

Ports:
hclk  in  1  clock
hrstn  in  1  reset, active-low; one clock, reset asynchronous active-low
ifu_req  in  1  IFU fetch request; held with ifu_addr until ifu_gnt
ifu_addr  in  32  fetch address (word access)
ifu_gnt  out  1  one-cycle pulse: IFU request accepted
ifu_done  out  1  one-cycle pulse: fetch complete
ifu_rdata  out  32  fetched word, valid with ifu_done
ifu_err  out  1  error flag, valid with ifu_done
mau_req  in  1  MAU request; held with fields until mau_gnt
mau_addr  in  32  byte address
mau_write  in  1  1=store, 0=load
mau_wdata  in  32  store data
mau_size  in  2  0=byte, 1=half, 2=word
mau_gnt  out  1  one-cycle pulse: MAU request accepted
mau_done  out  1  one-cycle pulse: transfer complete
mau_rdata  out  32  raw hrdata for loads (no extension here), valid with mau_done; 0 for stores
mau_err  out  1  error flag, valid with mau_done
haddr  out  32  AHB address
hwrite  out  1  AHB write
hwdata  out  32  AHB write data
hsize  out  3  AHB size
hburst  out  3  constant 0 (SINGLE)
hprot  out  7  3'b0 & 4'b0011 for MAU (data, privileged); 4'b0010 for IFU (opcode)
htrans  out  2  IDLE=0 / NONSEQ=2 only
hmastlock  out  1  constant 0
hready  in  1  AHB ready
hresp  in  1  AHB error response
owner  out  1  0=IFU, 1=MAU; last/current grantee (debug)

Behaviour:
- Reset (async, hrstn low):
  - State goes to IDLE immediately.
  - All registered outputs go to 0: haddr, hwrite, hwdata, hsize, hprot, htrans, all gnt/done/err/rdata, owner.
  - Starvation counter clears.
  - An in-flight transfer is abandoned; requesters reissue after reset.
- States:
  - IDLE: htrans=0. If any req is high, pick a winner. Registered at the edge: gnt pulse to the winner, owner, latched address/write/size/wdata.
    - Aligned request -> ADDR, with htrans=NONSEQ and the address-phase signals driven.
    - Misaligned request (half with addr[0]=1; word with addr[1:0]!=0; mau_size=3 treated as misaligned) -> MISALIGN. No bus transfer; htrans stays 0.
  - ADDR: htrans=NONSEQ, address-phase signals held.
    - hready=1 -> DATA. htrans<=0; hwdata<=latched wdata for writes (0 for reads).
    - hready=0 -> stay in ADDR.
  - DATA: wait for hready=1.
    - On that edge: done pulse to owner, with rdata<=hrdata (reads only), err<=hresp, hwdata<=0 -> IDLE.
    - hresp=1 with hready=0 (first cycle of the two-cycle error): remain in DATA.
  - MISALIGN: one cycle. done=1 and err=1 to owner, rdata=0 -> IDLE.
- Latency: minimum 3 cycles from IDLE selection to done pulse with zero wait states. Next selection happens in the cycle after done (IDLE).
- Arbitration:
  - MAU has priority over IFU.
  - starve_cnt increments on each MAU grant while ifu_req=1. It clears on an IFU grant, or whenever ifu_req=0 in IDLE.
  - If starve_cnt==STARVE_MAX and both requesters are pending, IFU wins.
  - starve_cnt saturates at STARVE_MAX.
- Requests are ignored outside IDLE. The loser's req stays pending and is not acknowledged.
- The requester may drop req the cycle after gnt; fields need not be held after gnt.
- IFU transfers: hsize=2, hwrite=0.
- MAU transfers: hsize={1'b0,mau_size}.
- gnt and done are never asserted to both requesters in the same cycle. Exactly one done follows each gnt.
- Simultaneous new req and done: not sampled until IDLE.

Test Plan:
- Reset/idle: hrstn low mid-DATA of a MAU load -> all outputs 0 immediately, state IDLE; after release with no req, htrans stays 0.
- Single IFU fetch: ifu_req, addr 0x100, hrdata 0xDEADBEEF, hready=1 -> ifu_gnt in cycle 1; haddr=0x100, htrans=2, hsize=2 in cycle 1; ifu_done with ifu_rdata=0xDEADBEEF, ifu_err=0 in cycle 3.
- MAU store with waits: addr 0x2002, size=1, wdata 0x1234, hready low 2 cycles in the data phase -> hwrite=1, hsize=1, hwdata=0x1234 throughout the data phase; mau_done 2 cycles later than the zero-wait case.
- Priority/starvation: both req continuously, STARVE_MAX=4 -> grant order MAU×4, IFU, MAU×4, IFU.
- Misaligned: mau word to 0x1001 -> mau_gnt, then mau_done with mau_err=1 the next cycle; htrans never leaves 0.
- Bus error: IFU fetch with hresp=1 for 2 cycles (hready 0 then 1) -> ifu_done with ifu_err=1 after the second error cycle; the next request proceeds normally.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
//   Shares one AHB-Lite master port between the instruction fetch unit (IFU)
//   and the memory access unit (MAU). Exactly one transfer is in flight at a
//   time. Each transfer is a SINGLE, NONSEQ access that passes through the
//   address and data phases. Read data and error status go back to the
//   requester that won arbitration.
//
// Ports
//   hclk, hrstn             clock, asynchronous active-low reset
//   ifu_req/ifu_addr        fetch request (word access)
//   ifu_gnt/ifu_done        accept pulse / completion pulse
//   ifu_rdata/ifu_err       fetched word and error flag, valid with ifu_done
//   mau_req/addr/write/wdata/size  load/store request
//   mau_gnt/mau_done        accept pulse / completion pulse
//   mau_rdata/mau_err       raw load data (0 for stores) and error flag, valid with mau_done
//   haddr..hmastlock        AHB-Lite master outputs
//   hready, hresp, hrdata   AHB-Lite master inputs
//   owner                   last or current grantee (0=IFU, 1=MAU)
//   dbg_state               FSM state (0=IDLE, 1=ADDR, 2=DATA, 3=MISALIGN)
//
// Handshake: a requester raises req and holds its fields stable until it
// sees a one-cycle gnt pulse. The request is sampled only in IDLE. After
// gnt, the requester may drop req or change its fields. Exactly one done
// pulse follows each gnt.
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_done,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        mau_req,
    input  logic [31:0] mau_addr,
    input  logic        mau_write,
    input  logic [31:0] mau_wdata,
    input  logic [1:0]  mau_size,
    output logic        mau_gnt,
    output logic        mau_done,
    output logic [31:0] mau_rdata,
    output logic        mau_err,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [31:0] hwdata,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [6:0]  hprot,
    output logic [1:0]  htrans,
    output logic        hmastlock,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata,
    output logic        owner,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ADDR     = 2'd1,
        S_DATA     = 2'd2,
        S_MISALIGN = 2'd3
    } state_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    state_t      r_state;
    logic [3:0]  r_starve;
    logic        r_write;
    logic [31:0] r_wdata;

    logic        w_starved;
    logic        w_pick_ifu;
    logic        w_pick_mau;
    logic [31:0] w_sel_addr;
    logic [1:0]  w_sel_size;
    logic        w_misalign;

    // MAU normally wins. IFU wins when it is alone, or when it has watched
    // STARVE_MAX back-to-back MAU grants.
    always_comb begin
        w_starved  = (r_starve == LP_STARVE_MAX);
        w_pick_ifu = ifu_req && (!mau_req || w_starved);
        w_pick_mau = mau_req && !w_pick_ifu;
        w_sel_addr = w_pick_ifu ? ifu_addr : mau_addr;
        w_sel_size = w_pick_ifu ? 2'd2 : mau_size;
        case (w_sel_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = w_sel_addr[0];
            2'd2:    w_misalign = |w_sel_addr[1:0];
            default: w_misalign = 1'b1;   // size 3 is not a legal MAU access
        endcase
    end

    assign hburst    = 3'b000;
    assign hmastlock = 1'b0;
    assign dbg_state = r_state;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_state   <= S_IDLE;
            r_starve  <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            ifu_gnt   <= 1'b0;
            ifu_done  <= 1'b0;
            ifu_rdata <= '0;
            ifu_err   <= 1'b0;
            mau_gnt   <= 1'b0;
            mau_done  <= 1'b0;
            mau_rdata <= '0;
            mau_err   <= 1'b0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hwdata    <= '0;
            hsize     <= '0;
            hprot     <= '0;
            htrans    <= 2'b00;
            owner     <= 1'b0;
        end else begin
            ifu_gnt  <= 1'b0;
            mau_gnt  <= 1'b0;
            ifu_done <= 1'b0;
            mau_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    htrans <= 2'b00;
                    // The counter tracks only MAU wins that IFU actually waited through.
                    if (w_pick_ifu || !ifu_req) begin
                        r_starve <= '0;
                    end else if (w_pick_mau && (r_starve != LP_STARVE_MAX)) begin
                        r_starve <= r_starve + 4'd1;
                    end
                    if (w_pick_ifu || w_pick_mau) begin
                        ifu_gnt <= w_pick_ifu;
                        mau_gnt <= w_pick_mau;
                        owner   <= w_pick_mau;
                        r_write <= w_pick_mau && mau_write;
                        r_wdata <= mau_wdata;
                        if (w_misalign) begin
                            r_state <= S_MISALIGN;
                        end else begin
                            r_state <= S_ADDR;
                            htrans  <= 2'b10;
                            haddr   <= w_sel_addr;
                            hwrite  <= w_pick_mau && mau_write;
                            hsize   <= {1'b0, w_sel_size};
                            hprot   <= w_pick_ifu ? 7'h02 : 7'h03;
                        end
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        r_state <= S_DATA;
                        htrans  <= 2'b00;
                        hwdata  <= r_write ? r_wdata : 32'h0;
                    end
                end
                S_DATA: begin
                    // A two-cycle ERROR response shows hresp=1 with hready=0
                    // first. We wait here until the cycle that completes it.
                    if (hready) begin
                        r_state <= S_IDLE;
                        hwdata  <= 32'h0;
                        if (owner) begin
                            mau_done  <= 1'b1;
                            mau_rdata <= r_write ? 32'h0 : hrdata;
                            mau_err   <= hresp;
                        end else begin
                            ifu_done  <= 1'b1;
                            ifu_rdata <= hrdata;
                            ifu_err   <= hresp;
                        end
                    end
                end
                S_MISALIGN: begin
                    r_state <= S_IDLE;
                    if (owner) begin
                        mau_done  <= 1'b1;
                        mau_rdata <= 32'h0;
                        mau_err   <= 1'b1;
                    end else begin
                        ifu_done  <= 1'b1;
                        ifu_rdata <= 32'h0;
                        ifu_err   <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
